// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (double dabble), one bit per cycle.
//   A start accepted in IDLE captures i_bin. SHIFT then runs BIN_WIDTH
//   add-3/shift steps over a DISPLAYS_NUM-digit scratch register. The edge
//   that completes the last step loads o_bcd_data/o_ovf and enters DONE,
//   where o_valid pulses for one cycle before the FSM returns to IDLE.
//
// Parameters
//   DISPLAYS_NUM : number of BCD digits produced (1..8)
//   BIN_WIDTH    : binary input width (4..27)
//
// Ports
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_bin      : unsigned input, sampled only when a start is accepted
//   i_start    : conversion request, accepted only while o_ready=1
//   o_ready    : idle, able to accept i_start
//   o_busy     : conversion shifting
//   o_valid    : one-cycle pulse marking a new result
//   o_bcd_data : packed BCD result, MS digit in the top nibble
//   o_ovf      : last converted value exceeded 10^DISPLAYS_NUM - 1
//
// Build option
//   BIN2BCD_SATURATE_EN : when defined, an overflowing result is loaded as
//                         all nines instead of the value mod 10^DISPLAYS_NUM.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int DISPLAYS_NUM = 4,
    parameter int BIN_WIDTH    = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [BIN_WIDTH-1:0]      i_bin,
    input  logic                      i_start,
    output logic                      o_ready,
    output logic                      o_busy,
    output logic                      o_valid,
    output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
    output logic                      o_ovf
);

    localparam int BW = DISPLAYS_NUM * 4;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DISPLAYS_NUM) - 64'd1;

    logic [1:0]           state_q, state_d;
    logic [BIN_WIDTH-1:0] sh_q, sh_d;
    logic [BW-1:0]        scr_q, scr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 ovf_cap_q, ovf_cap_d;
    logic [BW-1:0]        bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;

    logic [BW-1:0]        adj;
    logic [BW-1:0]        scr_step;
    logic [BIN_WIDTH-1:0] sh_step;
    logic [BW-1:0]        load_val;
    logic                 last_step;

    // Add-3 correction on every scratch digit that would reach >= 10 after
    // the shift.
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DISPLAYS_NUM; i++) begin
            if (scr_q[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = scr_q[i*4 +: 4] + 4'd3;
        end
    end

    // The bit leaving the top digit is dropped, so the result wraps
    // modulo 10^DISPLAYS_NUM.
    assign scr_step  = {adj[BW-2:0], sh_q[BIN_WIDTH-1]};
    assign sh_step   = {sh_q[BIN_WIDTH-2:0], 1'b0};
    assign last_step = (cnt_q == CW'(BIN_WIDTH - 1));

`ifdef BIN2BCD_SATURATE_EN
    assign load_val = ovf_cap_q ? {DISPLAYS_NUM{4'h9}} : scr_step;
`else
    assign load_val = scr_step;
`endif

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        ovf_cap_d = ovf_cap_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_SHIFT;
                    sh_d      = i_bin;
                    scr_d     = '0;
                    cnt_d     = '0;
                    // Overflow is judged on the full input value, not on
                    // the truncated digits.
                    ovf_cap_d = ({{(64-BIN_WIDTH){1'b0}}, i_bin} > MAX_VAL);
                end
            end
            S_SHIFT: begin
                scr_d = scr_step;
                sh_d  = sh_step;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = S_DONE;
                    bcd_d   = load_val;
                    ovf_d   = ovf_cap_q;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            scr_q     <= '0;
            cnt_q     <= '0;
            ovf_cap_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            ovf_cap_q <= ovf_cap_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_busy     = (state_q == S_SHIFT);
    assign o_valid    = (state_q == S_DONE);
    assign o_bcd_data = bcd_q;
    assign o_ovf      = ovf_q;

endmodule
